adc_drp_reader: RTL and testbench

- Sequences XADC DRP reads and supplies signed 16-bit samples to the distance LUT stage (adc_lut) and the PID front end.
- Runs with the XADC in continuous-sequence mode. On each end-of-conversion it reads the just-converted channel register over DRP.
- Routes the result to the diagonal or side sensor output and pulses that output's valid strobe.
- Sits between the XADC primitive and adc_lut in the wall-follower datapath.

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_drp_reader.sv | 127 ++++++++++++
 tb/tb_adc_drp_reader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the XADC DRP reader and its bench.
package adc_pkg;

  localparam int ADC_W = 16;
  localparam int CH_W  = 5;

  // XADC channel_out codes of the two IR sensors
  localparam logic [CH_W-1:0] DEF_CH_DIAG = 5'h13;  // VAUX3
  localparam logic [CH_W-1:0] DEF_CH_SIDE = 5'h1B;  // VAUX11

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/adc_drp_reader.sv
// On every XADC end-of-conversion, read the converted channel over DRP and
// route the raw signed result to the diagonal or side sensor output.
module adc_drp_reader
  import adc_pkg::*;
#(
  parameter logic [CH_W-1:0] CH_DIAG     = DEF_CH_DIAG,
  parameter logic [CH_W-1:0] CH_SIDE     = DEF_CH_SIDE,
  parameter int              TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    eoc_in,
  input  logic [CH_W-1:0]         channel_in,
  output logic                    drp_den,
  output logic                    drp_dwe,
  output logic [6:0]              drp_daddr,
  output logic [15:0]             drp_di,
  input  logic                    drp_drdy,
  input  logic [15:0]             drp_do,
  output logic signed [ADC_W-1:0] adc_data_diag,
  output logic                    adc_valid_diag,
  output logic signed [ADC_W-1:0] adc_data_side,
  output logic                    adc_valid_side,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state;
  logic [CH_W-1:0]   ch_lat;
  logic [CH_W-1:0]   pend_ch;
  logic              pending;
  logic [CNT_W-1:0]  cnt;
  logic              rd_done;

  // A read completes only on drdy while waiting; drdy during REQ or IDLE is stale
  assign rd_done   = (state == WAIT) && drp_drdy;

  // Read-only DRP access: enable and address are live only in the REQ cycle
  assign drp_den   = (state == REQ);
  assign drp_daddr = (state == REQ) ? {2'b00, ch_lat} : 7'd0;
  assign drp_dwe   = 1'b0;
  assign drp_di    = 16'd0;

  // Read sequencer; the counter starts at REQ so it measures cycles since drp_den
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ch_lat      <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            ch_lat <= pend_ch;
            cnt    <= '0;
            state  <= REQ;
          end else if (eoc_in) begin
            ch_lat <= channel_in;
            cnt    <= '0;
            state  <= REQ;
          end
        end
        REQ: begin
          cnt   <= cnt + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (drp_drdy) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-deep request buffer for conversions that land while a read is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      pend_ch <= '0;
      overrun <= 1'b0;
    end else if (state == IDLE) begin
      // A waiting request is launched now; a simultaneous eoc takes its place
      if (pending) begin
        pending <= eoc_in;
        if (eoc_in) pend_ch <= channel_in;
      end
    end else if (eoc_in) begin
      pend_ch <= channel_in;
      pending <= 1'b1;
      if (pending) overrun <= 1'b1;
    end
  end

  // Capture the DRP result into the sensor output that matches the channel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adc_data_diag  <= '0;
      adc_valid_diag <= 1'b0;
      adc_data_side  <= '0;
      adc_valid_side <= 1'b0;
    end else begin
      adc_valid_diag <= 1'b0;
      adc_valid_side <= 1'b0;
      if (rd_done) begin
        if (ch_lat == CH_DIAG) begin
          adc_data_diag  <= drp_do;
          adc_valid_diag <= 1'b1;
        end else if (ch_lat == CH_SIDE) begin
          adc_data_side  <= drp_do;
          adc_valid_side <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_drp_reader.sv
// Bench for adc_drp_reader: XADC DRP responder with programmable drdy latency,
// expected-response queues filled at issue time, and a strobe monitor.
module tb_adc_drp_reader;
  import adc_pkg::*;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        eoc_in = 1'b0;
  logic [4:0]  channel_in = 5'd0;
  logic        drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic        drp_drdy = 1'b0;
  logic [15:0] drp_do = 16'd0;
  logic signed [15:0] adc_data_diag, adc_data_side;
  logic        adc_valid_diag, adc_valid_side, overrun, timeout_err;

  adc_drp_reader #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .eoc_in(eoc_in), .channel_in(channel_in),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_drdy(drp_drdy), .drp_do(drp_do),
    .adc_data_diag(adc_data_diag), .adc_valid_diag(adc_valid_diag),
    .adc_data_side(adc_data_side), .adc_valid_side(adc_valid_side),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        side;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];   // strobes the DUT must produce, in order
  logic [6:0]  addr_q[$];  // DRP addresses the DUT must issue, in order

  int n_checks = 0;
  int n_pass   = 0;
  int n_den = 0, n_den_exp = 0;
  int den_cyc = 0, strobe_cyc = 0;
  int epoch = 0;
  logic [15:0] m_diag = 16'd0, m_side = 16'd0;

  // responder controls, captured at drp_den
  int          rsp_lat  = 3;
  logic [15:0] rsp_data = 16'd0;
  logic        rsp_blip = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // XADC DRP responder: drdy is sampled by the DUT at the end of cycle den+lat
  initial begin : responder
    state_e      rsp_st;
    int          rem, cur_lat, cur_ep, cur_kind;
    logic [15:0] cur_d;
    logic [6:0]  ea;
    rsp_st = IDLE;
    rem = 0; cur_lat = 0; cur_ep = 0; cur_kind = 2; cur_d = 16'd0;
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      drp_do   = 16'($urandom);
      if (rsp_st == WAIT) begin
        rem--;
        if (rem == 0) begin
          drp_drdy = 1'b1;
          drp_do   = cur_d;
          if (cur_ep == epoch && cur_lat < TO && cur_kind != 2)
            exp_q.push_back('{side: (cur_kind == 1), data: cur_d});
          rsp_st = IDLE;
        end
      end
      if (drp_den && reset) begin
        n_den++;
        den_cyc = cyc;
        check("den_while_busy", 32'(rsp_st == WAIT), 32'(0));
        check("drp_dwe", 32'(drp_dwe), 32'(0));
        check("drp_di", 32'(drp_di), 32'(0));
        if (addr_q.size() == 0) begin
          check("unexpected_den", 32'(drp_daddr), 32'h7F);
          ea = 7'h7F;
        end else begin
          ea = addr_q.pop_front();
          check("drp_daddr", 32'(drp_daddr), 32'(ea));
        end
        if (rsp_blip) begin
          drp_drdy = 1'b1;
          drp_do   = 16'hDEAD;
        end
        if (rsp_lat > 0) begin
          rsp_st   = WAIT;
          rem      = rsp_lat;
          cur_lat  = rsp_lat;
          cur_d    = rsp_data;
          cur_ep   = epoch;
          cur_kind = (ea == {2'b00, DEF_CH_DIAG}) ? 0 : (ea == {2'b00, DEF_CH_SIDE}) ? 1 : 2;
        end
      end
    end
  end

  // Strobe monitor: every valid pulse must match the head of the expected queue
  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk);
      if (reset && (adc_valid_diag || adc_valid_side)) begin
        strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'({adc_valid_diag, adc_valid_side}), 32'(0));
        end else begin
          m = exp_q.pop_front();
          check("strobe_diag", 32'(adc_valid_diag), 32'(!m.side));
          check("strobe_side", 32'(adc_valid_side), 32'(m.side));
          if (m.side) begin
            check("side_data", 32'($unsigned(adc_data_side)), 32'(m.data));
            m_side = m.data;
          end else begin
            check("diag_data", 32'($unsigned(adc_data_diag)), 32'(m.data));
            m_diag = m.data;
          end
        end
      end
    end
  end

  task automatic pulse_eoc(input logic [4:0] ch);
    @(posedge clk); #1;
    eoc_in = 1'b1;
    channel_in = ch;
    @(posedge clk); #1;
    eoc_in = 1'b0;
    channel_in = 5'($urandom);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one conversion that the DUT will read immediately (DUT idle)
  task automatic read(input logic [4:0] ch, input int lat, input logic [15:0] d);
    rsp_lat  = lat;
    rsp_data = d;
    addr_q.push_back({2'b00, ch});
    n_den_exp++;
    pulse_eoc(ch);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_den"}, 32'(drp_den), 32'(0));
    check({tag, "_daddr"}, 32'(drp_daddr), 32'(0));
    check({tag, "_diag"}, 32'($unsigned(adc_data_diag)), 32'(0));
    check({tag, "_side"}, 32'($unsigned(adc_data_side)), 32'(0));
    check({tag, "_valids"}, 32'({adc_valid_diag, adc_valid_side}), 32'(0));
    check({tag, "_flags"}, 32'({overrun, timeout_err}), 32'(0));
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [4:0]  ch;
    int          lat;
    // reset state
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    wait_cyc(2);

    // basic diagonal read with latency check
    read(5'h13, 3, 16'h7FF0);
    check("basic_den", 32'(drp_den), 32'(1));
    check("basic_daddr", 32'(drp_daddr), 32'h13);
    wait_cyc(8);
    check("basic_diag", 32'($unsigned(adc_data_diag)), 32'h7FF0);
    check("basic_strobe_lat", 32'(strobe_cyc - den_cyc), 32'(4));

    // alternating channels
    read(5'h13, 5, 16'h8000);
    wait_cyc(10);
    read(5'h1B, 4, 16'h0000);
    wait_cyc(10);
    check("alt_diag", 32'($unsigned(adc_data_diag)), 32'h8000);
    check("alt_side", 32'($unsigned(adc_data_side)), 32'h0000);
    check("alt_overrun", 32'(overrun), 32'(0));

    // unmapped channel: read issued, outputs untouched
    read(5'h10, 3, 16'h1234);
    wait_cyc(8);
    check("unmapped_diag", 32'($unsigned(adc_data_diag)), 32'(m_diag));
    check("unmapped_side", 32'($unsigned(adc_data_side)), 32'(m_side));

    // drdy in the REQ cycle is ignored; the later one is taken
    rsp_blip = 1'b1;
    read(5'h1B, 5, 16'h4321);
    rsp_blip = 1'b0;
    wait_cyc(10);
    check("req_drdy_side", 32'($unsigned(adc_data_side)), 32'h4321);

    // longest accepted latency
    read(5'h1B, TO - 1, 16'hABC0);
    wait_cyc(TO + 4);
    check("lat_max_side", 32'($unsigned(adc_data_side)), 32'hABC0);
    check("lat_max_no_timeout", 32'(timeout_err), 32'(0));

    // timeout with a silent responder
    read(5'h1B, 0, 16'h5555);
    for (int i = 0; i < 200 && !timeout_err; i++) @(negedge clk);
    check("timeout_flag", 32'(timeout_err), 32'(1));
    check("timeout_delay", 32'(cyc - den_cyc), 32'(TO));
    wait_cyc(2);
    read(5'h13, 2, 16'h0120);
    check("after_timeout_den", 32'(drp_den), 32'(1));
    wait_cyc(6);
    check("after_timeout_diag", 32'($unsigned(adc_data_diag)), 32'h0120);

    // drdy arriving after the timeout is ignored
    read(5'h13, TO + 6, 16'h7777);
    wait_cyc(TO + 12);
    check("late_drdy_diag", 32'($unsigned(adc_data_diag)), 32'(m_diag));

    // pending and overrun: newer eoc overwrites the buffered one
    check("pre_overrun", 32'(overrun), 32'(0));
    rsp_lat = 10; rsp_data = 16'h1111;
    addr_q.push_back(7'h13); addr_q.push_back(7'h13);
    n_den_exp += 2;
    pulse_eoc(5'h13);
    pulse_eoc(5'h1B);
    pulse_eoc(5'h13);
    rsp_lat = 4; rsp_data = 16'h2222;
    wait_cyc(30);
    check("overrun_set", 32'(overrun), 32'(1));
    check("overrun_diag", 32'($unsigned(adc_data_diag)), 32'h2222);

    // asynchronous reset in the middle of a read
    read(5'h13, 20, 16'h3333);
    wait_cyc(5);
    #2;
    reset = 1'b0;
    epoch++;
    m_diag = 16'd0;
    m_side = 16'd0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    wait_cyc(25);
    check("postreset_diag", 32'($unsigned(adc_data_diag)), 32'(0));
    read(5'h1B, 3, 16'hF00D);
    wait_cyc(8);
    check("postreset_side", 32'($unsigned(adc_data_side)), 32'hF00D);

    // randomized reads from idle
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       ch = 5'h13;
        1:       ch = 5'h1B;
        default: ch = 5'($urandom_range(0, 31));
      endcase
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO - 1));
      read(ch, lat, 16'($urandom));
      wait_cyc((lat == 0) ? TO + 6 : lat + 6);
    end
    check("rand_diag_hold", 32'($unsigned(adc_data_diag)), 32'(m_diag));
    check("rand_side_hold", 32'($unsigned(adc_data_side)), 32'(m_side));

    // nothing left outstanding
    wait_cyc(4);
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));
    check("addr_q_empty", 32'(addr_q.size()), 32'(0));
    check("den_count", 32'(n_den), 32'(n_den_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
